// File: rtl/vect_store_pkg.sv
// Shared types and default sizing for the vector stream store block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vect_store_pkg;

  localparam int DEF_STREAMW = 32;
  localparam int DEF_NLANES  = 2;
  localparam int DEF_ADDRW   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Lane index width; a single-lane build still needs a 1-bit index.
  function automatic int lane_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vect_store_lane_shifter.sv
// One-vector holding register that serialises a vector beat into lane words.
// Latency: a loaded vector presents its lane 0 word on the next cycle.
// Backpressure: lanes advance only on advance; a load overrides and restarts at lane 0.
module vect_store_lane_shifter
  import vect_store_pkg::*;
#(
  parameter int STREAMW = DEF_STREAMW,
  parameter int NLANES  = DEF_NLANES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [NLANES*STREAMW-1:0] load_data,
  input  logic                      advance,
  output logic                      valid,
  output logic [STREAMW-1:0]        word,
  output logic                      last_lane
);

  localparam int LIW = lane_idx_w(NLANES);
  localparam int VW  = NLANES * STREAMW;

  logic [VW-1:0]  hold;
  logic [LIW-1:0] lane;
  logic           full;

  // The current word always sits in the low lane; non-final lanes shift down.
  // A load only coincides with advance when the final lane leaves, so it wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold <= '0;
      lane <= '0;
      full <= 1'b0;
    end else if (load) begin
      hold <= load_data;
      lane <= '0;
      full <= 1'b1;
    end else if (advance) begin
      if (last_lane) begin
        full <= 1'b0;
        lane <= '0;
      end else begin
        hold <= hold >> STREAMW;
        lane <= lane + LIW'(1);
      end
    end
  end

  assign valid     = full;
  assign word      = hold[STREAMW-1:0];
  assign last_lane = (lane == LIW'(NLANES - 1));

endmodule

// File: rtl/vect_stream_store.sv
// Stores len vector beats from a kernel stream as consecutive scalar word writes.
// Latency: vector accepted in cycle t shows lane 0 in t+1; done the cycle after the last write.
// Backpressure: wr_ready stalls the lane shifter; iready drops while the holding register is busy.
module vect_stream_store
  import vect_store_pkg::*;
#(
  parameter int STREAMW = DEF_STREAMW,
  parameter int NLANES  = DEF_NLANES,
  parameter int ADDRW   = DEF_ADDRW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDRW-1:0]          base_addr,
  input  logic [ADDRW-1:0]          len,
  input  logic                      ivalid,
  output logic                      iready,
  input  logic [NLANES*STREAMW-1:0] idata,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [ADDRW-1:0]          wr_addr,
  output logic [STREAMW-1:0]        wr_data,
  output logic                      busy,
  output logic                      done
);

  // Wide enough for len*NLANES at the largest len without overflow.
  localparam int WCW = ADDRW + $clog2(NLANES);

  state_t             state;
  logic [ADDRW-1:0]   len_q;
  logic [ADDRW-1:0]   vec_cnt;
  logic [WCW-1:0]     word_cnt;
  logic [WCW-1:0]     total_words;
  logic               last_word;
  logic               hold_vld;
  logic               last_lane;
  logic               load;
  logic               wr_fire;
  logic [STREAMW-1:0] word;

  assign wr_fire     = wr_valid && wr_ready;
  assign total_words = WCW'(len_q) * WCW'(NLANES);
  assign last_word   = (word_cnt == total_words - WCW'(1));

  // A new vector may enter only while the job still needs vectors and the
  // holding register is free or emptying this cycle (keeps back-to-back rate).
  assign iready = (state == ST_RUN) && (vec_cnt < len_q) &&
                  (!hold_vld || (wr_fire && last_lane));
  assign load   = ivalid && iready;

  assign wr_valid = hold_vld;
  assign wr_data  = word;

  vect_store_lane_shifter #(
    .STREAMW (STREAMW),
    .NLANES  (NLANES)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (idata),
    .advance   (wr_fire),
    .valid     (hold_vld),
    .word      (word),
    .last_lane (last_lane)
  );

  // Job control: start capture, vector/word counting, address walk, busy/done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_addr  <= '0;
      len_q    <= '0;
      vec_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state    <= ST_RUN;
              busy     <= 1'b1;
              len_q    <= len;
              vec_cnt  <= '0;
              word_cnt <= '0;
              wr_addr  <= base_addr;
            end
          end
        end
        ST_RUN: begin
          if (load) begin
            vec_cnt <= vec_cnt + ADDRW'(1);
          end
          if (wr_fire) begin
            wr_addr  <= wr_addr + ADDRW'(1);
            word_cnt <= word_cnt + WCW'(1);
            if (last_word) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vect_stream_store.sv
// Directed bench for vect_stream_store: basic job, backpressure, wrap, zero length,
// over-supply and reset abort, with hand-written expected write tables.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_vect_stream_store;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] len;
  logic        ivalid;
  logic        iready;
  logic [63:0] idata;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] exp_addr[$];
  logic [31:0] exp_dat[$];
  int          span;
  bit          spur;

  vect_stream_store #(.STREAMW(32), .NLANES(2), .ADDRW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .ivalid    (ivalid),
    .iready    (iready),
    .idata     (idata),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Beat i carries lane0 = 0xA0+i, lane1 = 0xB0+i.
  function automatic logic [63:0] beat(input int i);
    logic [31:0] l0, l1;
    l0 = 32'hA0 + i;
    l1 = 32'hB0 + i;
    return {l1, l0};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_iready"}, 32'(iready), 0);
    chk({tag, "_wr_valid"}, 32'(wr_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, wr_data, 0);
  endtask

  // rdy_mode 0: wr_ready held 1; 1: toggles 1,0,1,0...
  // abort_after > 0: pull reset once that many writes were accepted (returns with rst low).
  // glitch: pulse start with different parameters mid-job.
  task automatic run_job(input logic [15:0] b, input logic [15:0] n, input int offer,
                         input int rdy_mode, input int abort_after, input bit glitch);
    int          wi, bi, first_wc, last_wc;
    bit          stall, got_all, late_rdy, full_rdy, hold_bad, saw_done;
    logic [15:0] pa;
    logic [31:0] pd;
    wi = 0; bi = 0; first_wc = 0; last_wc = -10;
    stall = 0; got_all = 0; late_rdy = 0; full_rdy = 0; hold_bad = 0; saw_done = 0;
    pa = '0; pd = '0;

    @(negedge clk);
    start = 1'b1; base_addr = b; len = n; ivalid = 1'b0; wr_ready = 1'b0;

    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (glitch && cyc == 3) begin
        start = 1'b1; base_addr = 16'h0099; len = 16'd5;
      end else begin
        start = 1'b0;
      end
      wr_ready = (rdy_mode == 0) ? 1'b1 : (cyc % 2 == 0);
      ivalid   = (bi < offer);
      idata    = beat(bi);
      #1;
      if (abort_after > 0 && wi == abort_after) begin
        rst = 1'b0;
        #1;
        chk_all_zero("abort");
        start = 1'b0; ivalid = 1'b0; wr_ready = 1'b0;
        return;
      end
      if (cyc == 0) chk("busy_run", 32'(busy), 1);
      if (got_all && iready) late_rdy = 1;
      if (wr_valid && !wr_ready && iready) full_rdy = 1;
      if (ivalid && iready) begin
        bi++;
        if (bi == int'(n)) got_all = 1;
      end
      if (stall && (!wr_valid || wr_addr !== pa || wr_data !== pd)) hold_bad = 1;
      if (wr_valid) begin
        if (wr_ready) begin
          if (wi < exp_addr.size()) begin
            chk("wr_addr", 32'(wr_addr), 32'(exp_addr[wi]));
            chk("wr_data", wr_data, exp_dat[wi]);
          end else begin
            chk("extra_write", wi, exp_addr.size());
          end
          if (wi == 0) first_wc = cyc;
          last_wc = cyc;
          wi++;
          stall = 0;
        end else begin
          stall = 1; pa = wr_addr; pd = wr_data;
        end
      end
      if (done) begin
        saw_done = 1;
        chk("done_cycle", cyc, last_wc + 1);
        break;
      end
    end

    chk("done_seen", 32'(saw_done), 1);
    chk("n_writes", wi, 32'(n) * 2);
    chk("n_accepted", bi, 32'(n));
    chk("iready_after_len", 32'(late_rdy), 0);
    chk("iready_while_full", 32'(full_rdy), 0);
    chk("stall_stable", 32'(hold_bad), 0);
    span = last_wc - first_wc;
    start = 1'b0; ivalid = 1'b0; wr_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("done_pulse_end", 32'(done), 0);
    chk("busy_end", 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; base_addr = '0; len = '0;
    ivalid = 1'b0; idata = '0; wr_ready = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Basic job, full rate.
    exp_addr = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015};
    exp_dat  = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB2};
    run_job(16'h0010, 16'd3, 3, 0, 0, 1'b0);
    chk("basic_span", span, 5);

    // Same job under toggling wr_ready, plus an ignored start mid-job.
    run_job(16'h0010, 16'd3, 3, 1, 0, 1'b1);
    chk("bp_span", span, 10);

    // Address wrap.
    exp_addr = '{16'hFFFF, 16'h0000};
    exp_dat  = '{32'hA0, 32'hB0};
    run_job(16'hFFFF, 16'd1, 1, 0, 0, 1'b0);

    // Zero length: done next cycle, no writes.
    @(negedge clk);
    start = 1'b1; base_addr = 16'h0055; len = 16'd0; ivalid = 1'b1; idata = beat(0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("zero_done", 32'(done), 1);
    chk("zero_wr_valid", 32'(wr_valid), 0);
    chk("zero_iready", 32'(iready), 0);
    @(negedge clk);
    #1;
    chk("zero_done_end", 32'(done), 0);
    chk("zero_wr_valid_end", 32'(wr_valid), 0);
    ivalid = 1'b0;

    // Over-supply: 4 beats offered, 2 taken.
    exp_addr = '{16'h0040, 16'h0041, 16'h0042, 16'h0043};
    exp_dat  = '{32'hA0, 32'hB0, 32'hA1, 32'hB1};
    run_job(16'h0040, 16'd2, 4, 0, 0, 1'b0);

    // Reset after 3 of 6 writes.
    exp_addr = '{16'h0030, 16'h0031, 16'h0032, 16'h0033, 16'h0034, 16'h0035};
    exp_dat  = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB2};
    run_job(16'h0030, 16'd3, 3, 0, 3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    spur = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (done || busy || wr_valid) spur = 1;
    end
    chk("abort_no_done", 32'(spur), 0);

    exp_addr = '{16'h0020, 16'h0021};
    exp_dat  = '{32'hA0, 32'hB0};
    run_job(16'h0020, 16'd1, 1, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
